dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. It shares the memory between the core load/store unit (port 0) and the loader/debug port (port 1), and uses round-robin grant. It filters misaligned and out-of-range accesses and returns each response, read data or write acknowledge, to the originating port at a fixed latency. It sits between the requesters and the memory's rwe/Addr/Data_in/Data_out interface.

## Interface
- ADDR_W, 7, byte address width
- DATA_W, 32, data width
- MEM_BYTES, 128, memory size in bytes
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  request valid, one bit per port
- req_ready  out  2  grant for this cycle; handshake = valid & ready
- req_rwe  in  2x2  op per port: 0 = LW, 1 = SW, 2 = SH, 3 = SB
- req_addr  in  2xADDR_W  byte address per port
- req_wdata  in  2xDATA_W  write data per port
- rsp_valid  out  2  response strobe per port, one cycle
- rsp_err  out  1  response is an error; qualified by rsp_valid
- rsp_rdata  out  DATA_W  LW data; 0 for stores and errors
- mem_en  out  1  memory command valid
- mem_rwe  out  2  memory op, same encoding as req_rwe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the cycle mem_en=1 with mem_rwe=0

## Operation
- At most one handshake per cycle.
  - req_ready is combinational from req_valid and the round-robin pointer `last`.
  - req_ready is one-hot or zero, and never depends on response state.
- Round-robin:
  - Only one port valid: that port is granted.
  - Both ports valid: grant the port that is not `last`.
  - `last` updates only on a handshake.
  - Reset sets `last` = 1, so port 0 wins the first contention.
- Legality check on the accepted request. Size is 4 / 4 / 2 / 1 bytes for rwe 0 / 1 / 2 / 3.
  - Misaligned: LW/SW with addr[1:0] ≠ 0, or SH with addr[0] ≠ 0.
  - Out of range: addr + size > MEM_BYTES.
  - An illegal request raises no mem_en and returns rsp_err=1 with rsp_rdata=0.
- A legal request is forwarded unchanged on mem_*. The originating port id, op and error flag travel with it in pipeline registers.
- Stores return rsp_valid with rsp_err=0 and rsp_rdata=0.
- No response backpressure: requesters must accept rsp_valid whenever it occurs.
- Three-state pipeline view per slot: EMPTY → ISSUED (mem cycle) → RESPOND (rsp cycle) → EMPTY. Slots fully overlap.

## Timing
- Cycle N: handshake on port p.
- Cycle N+1: mem_en/mem_rwe/mem_addr/mem_wdata are driven from registers, and mem_rdata is captured at the end of N+1.
- Cycle N+2: rsp_valid[p] = 1, with rsp_err and rsp_rdata registered.
- Throughput is one request per cycle, sustained; latency is exactly 2 cycles, including error responses.
- Outputs are 0 when idle: mem_en=0, mem_rwe=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Reset values: all registered outputs 0, both pipeline slots EMPTY, `last`=1.
- Reset asserted mid-operation:
  - In-flight commands and responses are discarded.
  - In the cycle after the reset edge, mem_en=0 and rsp_valid=0.
  - A handshake in a reset cycle is ignored.
- Simultaneous events:
  - A new handshake in N+1 coexists with the mem cycle of N and the response of N-1.
  - Responses to both ports never occur in the same cycle.
- Address arithmetic: addr + size is computed at ADDR_W+1 bits so that 127+4 does not wrap.

## Structure
- Shared package dmem_pkg:
  - RWE_LW=0, RWE_SW=1, RWE_SH=2, RWE_SB=3.
  - MEM_BYTES.
  - A size-of-op function returning 1/2/4.
- One sub-module, rr_arb2: 2-input round-robin grant with the `last` register, advance on handshake, and reset to last=1.
- Legality check and the two-slot pipeline live in dmem_arbiter.

## Test plan
- Port 0 LW addr 8 with mem_rdata=7 in N+1 → rsp_valid=2'b01 in N+2, rsp_rdata=7, rsp_err=0; mem_addr=8 and mem_rwe=0 in N+1.
- Both ports valid for 4 cycles, port 0 SW addr 0 and port 1 SW addr 40 → grants 0,1,0,1; mem_addr sequence 0,40,0,40; rsp_valid alternates 01,10,01,10 two cycles later.
- Port 1 SW addr 6 → no mem_en; rsp_valid=2'b10, rsp_err=1, rsp_rdata=0 in N+2. Port 1 SH addr 6 → forwarded, rsp_err=0.
- Port 0 LW addr 124 → legal; LW addr 125 → misaligned error; SB addr 127 → legal; SH addr 127 → misaligned error; LW addr 126 → misaligned error.
- Back-to-back LW addr 0, 4, 8 on port 0 with mem_rdata 5, 16, 7 → rsp_rdata 5, 16, 7 in three consecutive cycles.
- Reset in N+1 after a handshake in N → mem_en=0 and rsp_valid=0 in N+2; the first contention after reset grants port 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: op encodings, memory size
// and the byte size of each op.
package dmem_pkg;

    localparam int MEM_BYTES = 128;

    typedef enum logic [1:0] {
        RWE_LW = 2'd0,
        RWE_SW = 2'd1,
        RWE_SH = 2'd2,
        RWE_SB = 2'd3
    } rwe_e;

    function automatic logic [2:0] op_size(input logic [1:0] rwe);
        case (rwe_e'(rwe))
            RWE_SH:  op_size = 3'd2;
            RWE_SB:  op_size = 3'd1;
            default: op_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter; the master
// modport is the requester/memory environment, the slave modport the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][1:0]        req_rwe;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;

    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic [DATA_W-1:0]      rsp_rdata;

    logic                   mem_en;
    logic [1:0]             mem_rwe;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport master (
        output req_valid, req_rwe, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_en, mem_rwe, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_rwe, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_en, mem_rwe, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant; `last` remembers the most recently served port
// and only moves when a grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       handshake
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        // A grant is only ever given to a valid port, so any grant is a handshake.
        handshake = |grant;
        last_d    = handshake ? grant[1] : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between two requesters: round-robin
// grant, legality filtering, and a two-stage issue/respond pipeline.
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = dmem_pkg::MEM_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    import dmem_pkg::*;

    logic [1:0]        grant;
    logic              hs;
    logic              port;

    logic [1:0]        acc_rwe;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W:0]   acc_end;
    logic              acc_misaligned;
    logic              acc_oor;
    logic              acc_legal;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_port_q, s1_port_d;
    logic              s1_err_q, s1_err_d;
    logic              s1_load_q, s1_load_d;
    logic              mem_en_q, mem_en_d;
    logic [1:0]        mem_rwe_q, mem_rwe_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .valid     (bus.req_valid),
        .grant     (grant),
        .handshake (hs)
    );

    assign bus.req_ready = grant;
    assign port          = grant[1];

    // End address is one bit wider than the address so 127+4 does not wrap.
    always_comb begin
        acc_rwe        = bus.req_rwe[port];
        acc_addr       = bus.req_addr[port];
        acc_wdata      = bus.req_wdata[port];
        acc_end        = {1'b0, acc_addr} + (ADDR_W+1)'(op_size(acc_rwe));
        acc_misaligned = 1'b0;
        case (rwe_e'(acc_rwe))
            RWE_LW, RWE_SW: acc_misaligned = |acc_addr[1:0];
            RWE_SH:         acc_misaligned = acc_addr[0];
            default:        acc_misaligned = 1'b0;
        endcase
        acc_oor   = acc_end > (ADDR_W+1)'(MEM_BYTES);
        acc_legal = !acc_misaligned && !acc_oor;
    end

    always_comb begin
        s1_valid_d  = hs;
        s1_port_d   = hs & port;
        s1_err_d    = hs & !acc_legal;
        s1_load_d   = hs && acc_legal && (acc_rwe == RWE_LW);
        mem_en_d    = hs && acc_legal;
        mem_rwe_d   = mem_en_d ? acc_rwe   : '0;
        mem_addr_d  = mem_en_d ? acc_addr  : '0;
        mem_wdata_d = mem_en_d ? acc_wdata : '0;

        rsp_valid_d = 2'b00;
        if (s1_valid_q) begin
            rsp_valid_d = s1_port_q ? 2'b10 : 2'b01;
        end
        rsp_err_d   = s1_valid_q & s1_err_q;
        rsp_rdata_d = s1_load_q ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_port_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_load_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rwe_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_port_q   <= s1_port_d;
            s1_err_q    <= s1_err_d;
            s1_load_q   <= s1_load_d;
            mem_en_q    <= mem_en_d;
            mem_rwe_q   <= mem_rwe_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rwe   = mem_rwe_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: each accepted request queues its expected
// memory command and response, and a monitor compares them every cycle.
module tb_dmem_arbiter;

    localparam logic [1:0] OP_LW = 2'd0;
    localparam logic [1:0] OP_SW = 2'd1;
    localparam logic [1:0] OP_SH = 2'd2;
    localparam logic [1:0] OP_SB = 2'd3;

    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          due;
        logic [1:0]  rwe;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } mem_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic tb_last = 1'b1;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    logic [31:0] rdata_at[int];

    logic [1:0]  m_rv;
    logic        m_err;
    logic [31:0] m_rd;
    logic        m_en;
    logic [1:0]  m_rwe;
    logic [6:0]  m_addr;
    logic [31:0] m_wd;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_BYTES(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] mem_val(input int c);
        if (rdata_at.exists(c)) return rdata_at[c];
        return 32'hC0DE_0000 | (32'(c) & 32'h0000_FFFF);
    endfunction

    // Memory read data for the current cycle; the bench picks it, so it is known in advance.
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = mem_val(cyc);
    end

    function automatic bit is_legal(input logic [1:0] op, input logic [6:0] a);
        int sz;
        sz = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
        if ((op == OP_LW || op == OP_SW) && a[1:0] != 2'b00) return 1'b0;
        if (op == OP_SH && a[0]) return 1'b0;
        if (int'(a) + sz > 128) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            m_rv = 2'b00; m_err = 1'b0; m_rd = 32'h0;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                m_rv  = (rsp_q[0].port == 1) ? 2'b10 : 2'b01;
                m_err = rsp_q[0].err;
                m_rd  = rsp_q[0].rdata;
                void'(rsp_q.pop_front());
            end
            checks++;
            if (bus.rsp_valid !== m_rv || bus.rsp_err !== m_err || bus.rsp_rdata !== m_rd) begin
                errors++;
                $display("[TB] FAIL rsp cyc %0d: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                         cyc, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, m_rv, m_err, m_rd);
            end

            m_en = 1'b0; m_rwe = 2'b00; m_addr = 7'h0; m_wd = 32'h0;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                m_en   = 1'b1;
                m_rwe  = mem_q[0].rwe;
                m_addr = mem_q[0].addr;
                m_wd   = mem_q[0].wdata;
                void'(mem_q.pop_front());
            end
            checks++;
            if (bus.mem_en !== m_en || bus.mem_rwe !== m_rwe || bus.mem_addr !== m_addr || bus.mem_wdata !== m_wd) begin
                errors++;
                $display("[TB] FAIL mem cyc %0d: got en=%b rwe=%0d addr=%0d wdata=%h, want en=%b rwe=%0d addr=%0d wdata=%h",
                         cyc, bus.mem_en, bus.mem_rwe, bus.mem_addr, bus.mem_wdata, m_en, m_rwe, m_addr, m_wd);
            end
        end
    end

    task automatic flush(input int c);
        rsp_t keep_r[$];
        mem_t keep_m[$];
        foreach (rsp_q[i]) if (rsp_q[i].due <= c) keep_r.push_back(rsp_q[i]);
        foreach (mem_q[i]) if (mem_q[i].due <= c) keep_m.push_back(mem_q[i]);
        rsp_q = keep_r;
        mem_q = keep_m;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cycle of requests, checks the grant and queues expectations for the winner.
    task automatic issue(input logic [1:0] v,
                         input logic [1:0] op0, input logic [6:0] a0, input logic [31:0] d0,
                         input logic [1:0] op1, input logic [6:0] a1, input logic [31:0] d1);
        logic [1:0]  g;
        logic [1:0]  op;
        logic [6:0]  a;
        logic [31:0] d;
        rsp_t        r;
        mem_t        m;
        bus.req_valid    = v;
        bus.req_rwe[0]   = op0;
        bus.req_addr[0]  = a0;
        bus.req_wdata[0] = d0;
        bus.req_rwe[1]   = op1;
        bus.req_addr[1]  = a1;
        bus.req_wdata[1] = d1;
        @(negedge clk);
        case (v)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = tb_last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        checks++;
        if (bus.req_ready !== g) begin
            errors++;
            $display("[TB] FAIL grant cyc %0d valid=%b: got ready=%b, want %b", cyc, v, bus.req_ready, g);
        end
        if (reset) begin
            flush(cyc);
            tb_last = 1'b1;
        end else if (g != 2'b00) begin
            tb_last = g[1];
            op = g[1] ? op1 : op0;
            a  = g[1] ? a1  : a0;
            d  = g[1] ? d1  : d0;
            r.due   = cyc + 2;
            r.port  = g[1] ? 1 : 0;
            r.err   = !is_legal(op, a);
            r.rdata = (!r.err && op == OP_LW) ? mem_val(cyc + 1) : 32'h0;
            rsp_q.push_back(r);
            if (!r.err) begin
                m.due = cyc + 1; m.rwe = op; m.addr = a; m.wdata = d;
                mem_q.push_back(m);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.req_valid = 2'b00;
        repeat (n) begin
            @(negedge clk);
            flush(cyc);
            @(posedge clk);
            #1;
        end
        tb_last = 1'b1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b00 || bus.mem_en !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got ready=%b mem_en=%b rsp_valid=%b rdata=%h, want 00 0 00 0",
                     bus.req_ready, bus.mem_en, bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) begin
            issue(2'b11, OP_SW, 7'd0, 32'h1111_0000 + 32'(i), OP_SW, 7'd40, 32'h2222_0000 + 32'(i));
        end
        idle(3);
    endtask

    task automatic test_single_lw();
        rdata_at[cyc + 1] = 32'd7;
        issue(2'b01, OP_LW, 7'd8, 32'h0, OP_LW, 7'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 7'd8 || bus.mem_rwe !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lw_mem: got en=%b addr=%0d rwe=%0d, want 1 8 0", bus.mem_en, bus.mem_addr, bus.mem_rwe);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'd7 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_rsp: got valid=%b rdata=%h err=%b, want 01 7 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_misaligned();
        issue(2'b10, OP_LW, 7'd0, 32'h0, OP_SW, 7'd6, 32'hDEAD_0001);
        issue(2'b10, OP_LW, 7'd0, 32'h0, OP_SH, 7'd6, 32'hBEEF_0002);
        issue(2'b01, OP_SB, 7'd3, 32'h0000_00A5, OP_SW, 7'd0, 32'h0);
        idle(3);
    endtask

    task automatic test_boundary();
        logic [1:0] ops [5];
        logic [6:0] addrs [5];
        ops   = '{OP_LW, OP_LW, OP_SB, OP_SH, OP_LW};
        addrs = '{7'd124, 7'd125, 7'd127, 7'd127, 7'd126};
        for (int i = 0; i < 5; i++) begin
            issue(2'b01, ops[i], addrs[i], 32'hA000_0000 + 32'(i), OP_LW, 7'd0, 32'h0);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals = '{32'd5, 32'd16, 32'd7};
        for (int i = 0; i < 3; i++) begin
            rdata_at[cyc + 1] = vals[i];
            issue(2'b01, OP_LW, 7'(4 * i), 32'h0, OP_LW, 7'd0, 32'h0);
        end
        idle(3);
    endtask

    task automatic test_mixed_stream();
        for (int i = 0; i < 6; i++) begin
            issue(2'(1 + (i % 3)), OP_LW, 7'(8 * i), 32'hB000_0000 + 32'(i),
                  OP_SH, 7'(2 * i + 1), 32'hC000_0000 + 32'(i));
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        issue(2'b01, OP_LW, 7'd12, 32'h0, OP_LW, 7'd0, 32'h0);
        reset = 1'b1;
        issue(2'b11, OP_SW, 7'd0, 32'h1, OP_SW, 7'd4, 32'h2);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid: got mem_en=%b rsp_valid=%b, want 0 00", bus.mem_en, bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        issue(2'b11, OP_LW, 7'd16, 32'h0, OP_LW, 7'd20, 32'h0);
        issue(2'b11, OP_LW, 7'd16, 32'h0, OP_LW, 7'd20, 32'h0);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_rwe   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single_lw();
        test_misaligned();
        test_boundary();
        test_back_to_back();
        test_mixed_stream();
        test_reset_mid();
        checks++;
        if (rsp_q.size() != 0 || mem_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d rsp and %0d mem pending, want 0 0", rsp_q.size(), mem_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
